rv_writeback: RTL and testbench

// - W (writeback) stage of the uRV pipeline; sits directly downstream of the execute stage and the two-stage shifter.
// - Registers the X-stage result descriptor and selects the final rd value: ALU, shifter stage-2 output, multiplier output, or aligned load data.
// - Writes the register file and provides the W->X bypass.
// - Holds the pipeline, via a stall request, while a load is outstanding on the data bus.
//

---
 rtl/rv_writeback_pkg.sv | 24 ++
 rtl/rv_writeback_load_align.sv | 42 ++++
 rtl/rv_writeback.sv | 137 +++++++++++++
 tb/tb_rv_writeback.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_writeback_pkg.sv
// Shared encodings for the uRV writeback stage: result sources, load funct3 codes, FSM states.
`default_nettype none

package rv_writeback_pkg;

  localparam logic [1:0] RD_SOURCE_ALU     = 2'd0;
  localparam logic [1:0] RD_SOURCE_SHIFTER = 2'd1;
  localparam logic [1:0] RD_SOURCE_MUL     = 2'd2;
  localparam logic [1:0] RD_SOURCE_LOAD    = 2'd3;

  localparam logic [2:0] FUNC_LB  = 3'b000;
  localparam logic [2:0] FUNC_LH  = 3'b001;
  localparam logic [2:0] FUNC_LW  = 3'b010;
  localparam logic [2:0] FUNC_LBU = 3'b100;
  localparam logic [2:0] FUNC_LHU = 3'b101;

  typedef enum logic [0:0] {
    ST_IDLE      = 1'b0,
    ST_WAIT_LOAD = 1'b1
  } wb_state_t;

endpackage

`default_nettype wire

// File: rtl/rv_writeback_load_align.sv
// Load data aligner: picks the byte/half/word selected by funct3 and address, then sign/zero-extends.
`default_nettype none

module rv_writeback_load_align
  import rv_writeback_pkg::*;
(
  input  logic [31:0] i_data,
  input  logic [2:0]  i_fun,
  input  logic [1:0]  i_addr,
  output logic [31:0] o_value
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_data[7:0];
    case (i_addr)
      2'd0:    w_byte = i_data[7:0];
      2'd1:    w_byte = i_data[15:8];
      2'd2:    w_byte = i_data[23:16];
      default: w_byte = i_data[31:24];
    endcase
  end

  // Half selection uses addr[1] only; misaligned addr[0] is ignored.
  assign w_half = i_addr[1] ? i_data[31:16] : i_data[15:0];

  always_comb begin
    o_value = i_data;
    case (i_fun)
      FUNC_LB:  o_value = {{24{w_byte[7]}}, w_byte};
      FUNC_LBU: o_value = {24'd0, w_byte};
      FUNC_LH:  o_value = {{16{w_half[15]}}, w_half};
      FUNC_LHU: o_value = {16'd0, w_half};
      default:  o_value = i_data;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rv_writeback.sv
// uRV W stage: registers the X result, selects rd value, writes the register file and stalls on pending loads.
`default_nettype none

module rv_writeback
  import rv_writeback_pkg::*;
#(
  parameter bit          g_with_hw_mul  = 1'b1,
  parameter int unsigned g_load_timeout = 0
)(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        x_valid_i,
  input  logic [4:0]  x_rd_i,
  input  logic        x_rd_write_i,
  input  logic [1:0]  x_rd_source_i,
  input  logic [31:0] x_rd_value_i,
  input  logic [2:0]  x_fun_i,
  input  logic [1:0]  x_dm_addr_i,
  input  logic [31:0] w_shifter_rd_value_i,
  input  logic [31:0] w_mul_rd_value_i,
  input  logic [31:0] dm_data_l_i,
  input  logic        dm_load_done_i,
  output logic        w_stall_req_o,
  output logic        rf_rd_write_o,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_rd_value_o,
  output logic        w_bypass_rd_write_o,
  output logic        w_load_timeout_o
);

  localparam int CNT_W = (g_load_timeout > 1) ? $clog2(g_load_timeout + 1) : 1;

  wb_state_t         r_state;
  logic              r_valid;
  logic [4:0]        r_rd;
  logic              r_rd_write;
  logic [1:0]        r_src;
  logic [31:0]       r_value;
  logic [2:0]        r_fun;
  logic [1:0]        r_addr;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_is_load;
  logic              w_timeout;
  logic              w_stall;
  logic              w_retire;
  logic              w_write;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [31:0]       w_load_value;
  logic [31:0]       w_rd_value;

  rv_writeback_load_align u_load_align (
    .i_data  (dm_data_l_i),
    .i_fun   (r_fun),
    .i_addr  (r_addr),
    .o_value (w_load_value)
  );

  assign w_is_load = r_valid && (r_src == RD_SOURCE_LOAD);
  assign w_cnt_inc = r_cnt + 1'b1;

  // Done has priority: a timeout only fires when data has not arrived this cycle.
  assign w_timeout = (g_load_timeout != 0) && (r_state == ST_WAIT_LOAD) &&
                     !dm_load_done_i && (w_cnt_inc == CNT_W'(g_load_timeout));

  assign w_stall = ((r_state == ST_IDLE) && w_is_load && !dm_load_done_i) ||
                   ((r_state == ST_WAIT_LOAD) && !dm_load_done_i && !w_timeout);

  assign w_retire = r_valid && !w_stall;
  assign w_write  = w_retire && !w_timeout && r_rd_write && (r_rd != 5'd0);

  always_comb begin
    w_rd_value = r_value;
    case (r_src)
      RD_SOURCE_SHIFTER: w_rd_value = w_shifter_rd_value_i;
      RD_SOURCE_MUL:     w_rd_value = g_with_hw_mul ? w_mul_rd_value_i : r_value;
      RD_SOURCE_LOAD:    w_rd_value = w_load_value;
      default:           w_rd_value = r_value;
    endcase
  end

  // Outputs are forced low while reset is asserted, ahead of the synchronous clear.
  assign w_stall_req_o       = rst_i && w_stall;
  assign rf_rd_write_o       = rst_i && w_write;
  assign w_bypass_rd_write_o = rst_i && w_write;
  assign rf_rd_o             = rst_i ? r_rd : 5'd0;
  assign rf_rd_value_o       = rst_i ? w_rd_value : 32'd0;
  assign w_load_timeout_o    = rst_i && w_timeout;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state    <= ST_IDLE;
      r_valid    <= 1'b0;
      r_rd       <= 5'd0;
      r_rd_write <= 1'b0;
      r_src      <= RD_SOURCE_ALU;
      r_value    <= 32'd0;
      r_fun      <= 3'd0;
      r_addr     <= 2'd0;
      r_cnt      <= '0;
    end else begin
      if (!w_stall) begin
        r_valid    <= x_valid_i;
        r_rd       <= x_rd_i;
        r_rd_write <= x_rd_write_i;
        r_src      <= x_rd_source_i;
        r_value    <= x_rd_value_i;
        r_fun      <= x_fun_i;
        r_addr     <= x_dm_addr_i;
      end

      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_is_load && !dm_load_done_i) begin
            r_state <= ST_WAIT_LOAD;
          end
        end
        ST_WAIT_LOAD: begin
          if (dm_load_done_i || w_timeout) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rv_writeback.sv
// Self-checking bench for rv_writeback: scoreboard of expected rf writes plus per-cycle status checks.
`default_nettype none

module tb_rv_writeback;
  import rv_writeback_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        x_valid_i;
  logic [4:0]  x_rd_i;
  logic        x_rd_write_i;
  logic [1:0]  x_rd_source_i;
  logic [31:0] x_rd_value_i;
  logic [2:0]  x_fun_i;
  logic [1:0]  x_dm_addr_i;
  logic [31:0] w_shifter_rd_value_i;
  logic [31:0] w_mul_rd_value_i;
  logic [31:0] dm_data_l_i;
  logic        dm_load_done_i;
  logic        w_stall_req_o;
  logic        rf_rd_write_o;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_rd_value_o;
  logic        w_bypass_rd_write_o;
  logic        w_load_timeout_o;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  rv_writeback #(
    .g_with_hw_mul  (1'b1),
    .g_load_timeout (4)
  ) dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .x_valid_i            (x_valid_i),
    .x_rd_i               (x_rd_i),
    .x_rd_write_i         (x_rd_write_i),
    .x_rd_source_i        (x_rd_source_i),
    .x_rd_value_i         (x_rd_value_i),
    .x_fun_i              (x_fun_i),
    .x_dm_addr_i          (x_dm_addr_i),
    .w_shifter_rd_value_i (w_shifter_rd_value_i),
    .w_mul_rd_value_i     (w_mul_rd_value_i),
    .dm_data_l_i          (dm_data_l_i),
    .dm_load_done_i       (dm_load_done_i),
    .w_stall_req_o        (w_stall_req_o),
    .rf_rd_write_o        (rf_rd_write_o),
    .rf_rd_o              (rf_rd_o),
    .rf_rd_value_o        (rf_rd_value_o),
    .w_bypass_rd_write_o  (w_bypass_rd_write_o),
    .w_load_timeout_o     (w_load_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic stall, input logic wr, input logic to);
    chk({tag, "_stall"}, {31'd0, w_stall_req_o}, {31'd0, stall});
    chk({tag, "_wr"}, {31'd0, rf_rd_write_o}, {31'd0, wr});
    chk({tag, "_byp"}, {31'd0, w_bypass_rd_write_o}, {31'd0, wr});
    chk({tag, "_to"}, {31'd0, w_load_timeout_o}, {31'd0, to});
  endtask

  task automatic next();
    @(posedge clk_i);
    #1;
  endtask

  // Present one instruction for a single capture edge; returns with it sitting in W.
  task automatic issue(input logic [4:0] rd, input logic wr, input logic [1:0] src,
                       input logic [31:0] val, input logic [2:0] fun, input logic [1:0] addr);
    x_valid_i     = 1'b1;
    x_rd_i        = rd;
    x_rd_write_i  = wr;
    x_rd_source_i = src;
    x_rd_value_i  = val;
    x_fun_i       = fun;
    x_dm_addr_i   = addr;
    next();
    x_valid_i     = 1'b0;
  endtask

  always @(negedge clk_i) begin
    if (rf_rd_write_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_write", {31'd0, rf_rd_write_o}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_rd", {27'd0, rf_rd_o}, {27'd0, e.rd});
        chk("sb_val", rf_rd_value_o, e.val);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [2:0]  ld_fun [9];
  logic [1:0]  ld_addr[9];
  logic [31:0] ld_exp [9];

  initial begin
    ld_fun[0] = FUNC_LB;  ld_addr[0] = 2'd3; ld_exp[0] = 32'hFFFF_FF80;
    ld_fun[1] = FUNC_LHU; ld_addr[1] = 2'd2; ld_exp[1] = 32'h0000_8012;
    ld_fun[2] = FUNC_LW;  ld_addr[2] = 2'd1; ld_exp[2] = 32'h8012_3456;
    ld_fun[3] = FUNC_LH;  ld_addr[3] = 2'd2; ld_exp[3] = 32'hFFFF_8012;
    ld_fun[4] = FUNC_LBU; ld_addr[4] = 2'd0; ld_exp[4] = 32'h0000_0056;
    ld_fun[5] = FUNC_LB;  ld_addr[5] = 2'd1; ld_exp[5] = 32'h0000_0034;
    ld_fun[6] = FUNC_LH;  ld_addr[6] = 2'd0; ld_exp[6] = 32'h0000_3456;
    ld_fun[7] = 3'b011;   ld_addr[7] = 2'd2; ld_exp[7] = 32'h8012_3456;
    ld_fun[8] = FUNC_LHU; ld_addr[8] = 2'd3; ld_exp[8] = 32'h0000_8012;

    rst_i                = 1'b0;
    x_valid_i            = 1'b1;
    x_rd_i               = 5'd9;
    x_rd_write_i         = 1'b1;
    x_rd_source_i        = RD_SOURCE_ALU;
    x_rd_value_i         = 32'h0000_DEAD;
    x_fun_i              = 3'd0;
    x_dm_addr_i          = 2'd0;
    w_shifter_rd_value_i = 32'd0;
    w_mul_rd_value_i     = 32'd0;
    dm_data_l_i          = 32'd0;
    dm_load_done_i       = 1'b0;

    repeat (2) next();
    @(negedge clk_i);
    chk_st("rst", 1'b0, 1'b0, 1'b0);
    chk("rst_rd", {27'd0, rf_rd_o}, 32'd0);
    chk("rst_val", rf_rd_value_o, 32'd0);
    next();
    rst_i     = 1'b1;
    x_valid_i = 1'b0;
    @(negedge clk_i);
    chk_st("post_rst", 1'b0, 1'b0, 1'b0);
    chk("post_rst_rd", {27'd0, rf_rd_o}, 32'd0);
    chk("post_rst_val", rf_rd_value_o, 32'd0);
    next();

    sb.push_back('{rd: 5'd5, val: 32'h0000_1234});
    issue(5'd5, 1'b1, RD_SOURCE_ALU, 32'h0000_1234, 3'd0, 2'd0);
    @(negedge clk_i);
    chk_st("alu", 1'b0, 1'b1, 1'b0);
    next();

    issue(5'd0, 1'b1, RD_SOURCE_ALU, 32'hFFFF_FFFF, 3'd0, 2'd0);
    @(negedge clk_i);
    chk_st("x0", 1'b0, 1'b0, 1'b0);
    next();

    issue(5'd6, 1'b0, RD_SOURCE_ALU, 32'h0000_0066, 3'd0, 2'd0);
    @(negedge clk_i);
    chk_st("no_rdwr", 1'b0, 1'b0, 1'b0);
    next();

    sb.push_back('{rd: 5'd3, val: 32'h8000_0000});
    issue(5'd3, 1'b1, RD_SOURCE_SHIFTER, 32'h1111_1111, 3'd0, 2'd0);
    w_shifter_rd_value_i = 32'h8000_0000;
    @(negedge clk_i);
    chk_st("shift", 1'b0, 1'b1, 1'b0);
    next();
    w_shifter_rd_value_i = 32'd0;

    sb.push_back('{rd: 5'd4, val: 32'h0BAD_F00D});
    issue(5'd4, 1'b1, RD_SOURCE_MUL, 32'h2222_2222, 3'd0, 2'd0);
    w_mul_rd_value_i = 32'h0BAD_F00D;
    @(negedge clk_i);
    chk_st("mul", 1'b0, 1'b1, 1'b0);
    next();
    w_mul_rd_value_i = 32'd0;

    // Loads whose data arrives in the first W cycle: no stall, aligned value written.
    dm_data_l_i = 32'h8012_3456;
    for (int i = 0; i < 9; i++) begin
      sb.push_back('{rd: 5'(20 + i), val: ld_exp[i]});
      issue(5'(20 + i), 1'b1, RD_SOURCE_LOAD, 32'd0, ld_fun[i], ld_addr[i]);
      dm_load_done_i = 1'b1;
      @(negedge clk_i);
      chk_st("ld_same", 1'b0, 1'b1, 1'b0);
      next();
      dm_load_done_i = 1'b0;
    end

    issue(5'd7, 1'b1, RD_SOURCE_LOAD, 32'd0, FUNC_LW, 2'd0);
    x_valid_i     = 1'b1;
    x_rd_i        = 5'd12;
    x_rd_write_i  = 1'b1;
    x_rd_source_i = RD_SOURCE_ALU;
    x_rd_value_i  = 32'h0000_0077;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk_st("ld_wait", 1'b1, 1'b0, 1'b0);
      next();
    end
    dm_data_l_i    = 32'hCAFE_F00D;
    dm_load_done_i = 1'b1;
    sb.push_back('{rd: 5'd7, val: 32'hCAFE_F00D});
    sb.push_back('{rd: 5'd12, val: 32'h0000_0077});
    @(negedge clk_i);
    chk_st("ld_done", 1'b0, 1'b1, 1'b0);
    next();
    dm_load_done_i = 1'b0;
    x_valid_i      = 1'b0;
    @(negedge clk_i);
    chk_st("held_alu", 1'b0, 1'b1, 1'b0);
    next();

    dm_data_l_i = 32'h0000_0055;
    issue(5'd8, 1'b1, RD_SOURCE_LOAD, 32'd0, FUNC_LW, 2'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk_st("to_wait", 1'b1, 1'b0, 1'b0);
      next();
    end
    @(negedge clk_i);
    chk("to_pulse", {31'd0, w_load_timeout_o}, 32'd1);
    chk("to_nowrite", {31'd0, rf_rd_write_o}, 32'd0);
    next();
    @(negedge clk_i);
    chk_st("to_after", 1'b0, 1'b0, 1'b0);
    next();

    issue(5'd9, 1'b1, RD_SOURCE_LOAD, 32'd0, FUNC_LW, 2'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk_st("dvt_wait", 1'b1, 1'b0, 1'b0);
      next();
    end
    dm_data_l_i    = 32'h1357_9BDF;
    dm_load_done_i = 1'b1;
    sb.push_back('{rd: 5'd9, val: 32'h1357_9BDF});
    @(negedge clk_i);
    chk_st("done_vs_to", 1'b0, 1'b1, 1'b0);
    next();
    dm_load_done_i = 1'b0;

    issue(5'd10, 1'b1, RD_SOURCE_LOAD, 32'd0, FUNC_LW, 2'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      chk_st("mid_wait", 1'b1, 1'b0, 1'b0);
      next();
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    chk_st("rst_mid", 1'b0, 1'b0, 1'b0);
    chk("rst_mid_rd", {27'd0, rf_rd_o}, 32'd0);
    next();
    rst_i          = 1'b1;
    dm_data_l_i    = 32'hFFFF_FFFF;
    dm_load_done_i = 1'b1;
    @(negedge clk_i);
    chk_st("late_done", 1'b0, 1'b0, 1'b0);
    next();
    dm_load_done_i = 1'b0;

    sb.push_back('{rd: 5'd13, val: 32'h0000_ABCD});
    issue(5'd13, 1'b1, RD_SOURCE_ALU, 32'h0000_ABCD, 3'd0, 2'd0);
    @(negedge clk_i);
    chk_st("post_mid_rst", 1'b0, 1'b1, 1'b0);
    next();

    @(negedge clk_i);
    chk("sb_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
